// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core-to-data-memory bus: address/data/enables in, read word, status and counters out
interface data_mem_responder_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      addr;
  logic [31:0]      wr_data;
  logic [3:0]       mem_write_en;
  logic             read_enable;
  logic             halt;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             err;
  logic [31:0]      err_addr;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  modport master (
    output addr, wr_data, mem_write_en, read_enable, halt,
    input  rd_data, rd_valid, err, err_addr, rd_count, wr_count
  );

  modport slave (
    input  addr, wr_data, mem_write_en, read_enable, halt,
    output rd_data, rd_valid, err, err_addr, rd_count, wr_count
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory with byte-enable stores, 1-cycle registered loads,
// sticky access-error capture, saturating access counters and a halt freeze
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state_q;
  state_t           state_d;
  logic             run;
  logic             rd_valid;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [AW-1:0]    word_idx;
  logic             addr_legal;
  logic [31:0]      cur_word;
  logic [31:0]      merged_word;

  logic             wr_req;
  logic             wr_commit;
  logic             wr_err;
  logic             rd_err;

  logic [31:0]      rd_data_q;
  logic             rd_ok_q;
  logic             rd_bad_q;
  logic [31:0]      rd_addr_q;
  logic             err_q;
  logic [31:0]      err_addr_q;
  logic [CNT_W-1:0] rd_count_q;
  logic [CNT_W-1:0] wr_count_q;

  assign word_idx   = bus.addr[AW+1:2];
  assign addr_legal = (bus.addr[1:0] == 2'b00) &&
                      ({2'b00, bus.addr[31:2]} < 32'(DEPTH_WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.halt) state_d = HALTED;
      default: state_d = HALTED;
    endcase
  end

  always_comb begin
    run      = (state_q == RUN);
    rd_valid = bus.read_enable & rd_ok_q & run;
  end

  // A store issued together with halt is dropped; an X enable fails the if and never writes.
  assign wr_req    = run & ~bus.halt & (|bus.mem_write_en);
  assign wr_commit = wr_req & addr_legal & ~rst;
  assign wr_err    = wr_req & ~addr_legal;
  // rd_bad_q only rises once an address has been sampled, so the first read after reset is never an error.
  assign rd_err    = run & bus.read_enable & rd_bad_q;

  always_comb begin
    cur_word    = mem[word_idx];
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (wr_commit && bus.mem_write_en[i]) begin
        merged_word[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_commit && bus.mem_write_en[i]) begin
        mem[word_idx][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_ok_q    <= 1'b0;
      rd_bad_q   <= 1'b0;
      rd_addr_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (run) begin
      // Write-first: a same-word load sees the merged post-store word.
      rd_data_q <= addr_legal ? merged_word : 32'h0;
      rd_ok_q   <= addr_legal;
      rd_bad_q  <= ~addr_legal;
      rd_addr_q <= bus.addr;
      if (rd_valid && (rd_count_q != '1)) begin
        rd_count_q <= rd_count_q + CNT_W'(1);
      end
      if (wr_commit && (wr_count_q != '1)) begin
        wr_count_q <= wr_count_q + CNT_W'(1);
      end
      if (!err_q && (rd_err || wr_err)) begin
        err_q      <= 1'b1;
        err_addr_q <= rd_err ? rd_addr_q : bus.addr;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
  assign bus.rd_count = rd_count_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and randomized bench for data_mem_responder against a behavioural memory model
module tb_data_mem_responder;
  localparam int DEPTH   = 1024;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if #(.CNT_W(CNT_W)) bus ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rd_data;
  logic [31:0] m_err_addr;
  logic [31:0] m_prev_addr;
  bit          m_rd_ok;
  bit          m_sampled;
  bit          m_err;
  bit          m_halted;
  int          m_rd_cnt;
  int          m_wr_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
  endfunction

  // Reference: what the memory and status must look like after each clock edge.
  always @(posedge clk) begin : model
    bit lg;
    bit rde;
    bit wre;
    int w;
    if (rst) begin
      m_rd_data  = 0;
      m_err      = 0;
      m_err_addr = 0;
      m_rd_cnt   = 0;
      m_wr_cnt   = 0;
      m_halted   = 0;
      m_rd_ok    = 0;
      m_sampled  = 0;
    end else if (!m_halted) begin
      lg = is_legal(bus.addr);
      w  = int'(bus.addr >> 2);
      if (bus.read_enable && m_rd_ok) m_rd_cnt = (m_rd_cnt < CNT_MAX) ? m_rd_cnt + 1 : CNT_MAX;
      rde = bus.read_enable && m_sampled && !m_rd_ok;
      wre = !bus.halt && (bus.mem_write_en != 0) && !lg;
      if (!m_err && (rde || wre)) begin
        m_err      = 1;
        m_err_addr = rde ? m_prev_addr : bus.addr;
      end
      if (!bus.halt && (bus.mem_write_en != 0) && lg) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_write_en[b]) m_mem[w][8*b +: 8] = bus.wr_data[8*b +: 8];
        m_wr_cnt = (m_wr_cnt < CNT_MAX) ? m_wr_cnt + 1 : CNT_MAX;
      end
      m_rd_data   = lg ? m_mem[w] : 32'h0;
      m_rd_ok     = lg;
      m_sampled   = 1;
      m_prev_addr = bus.addr;
      if (bus.halt) m_halted = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data",  bus.rd_data, m_rd_data);
      check("rd_valid", {31'b0, bus.rd_valid}, {31'b0, bus.read_enable & m_rd_ok & !m_halted});
      check("err",      {31'b0, bus.err}, {31'b0, m_err});
      check("err_addr", bus.err_addr, m_err_addr);
      check("rd_count", {16'b0, bus.rd_count}, m_rd_cnt);
      check("wr_count", {16'b0, bus.wr_count}, m_wr_cnt);
      assert (!$isunknown({bus.rd_valid, bus.err, bus.rd_count, bus.wr_count}))
        else $error("status outputs unknown");
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic re, input logic h);
    bus.addr         = a;
    bus.wr_data      = d;
    bus.mem_write_en = be;
    bus.read_enable  = re;
    bus.halt         = h;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic random_segment(input int cycles);
    logic [31:0] a;
    logic [3:0]  be;
    bit          halted_seen;
    int          r;
    halted_seen = 0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       a = $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
      else if (r < 6)  a = DEPTH * 4 + $urandom_range(0, 1000) * 4;
      else if (r < 60) a = $urandom_range(0, 15) * 4;
      else             a = $urandom_range(0, DEPTH - 1) * 4;
      be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      drive(a, $urandom, be, 1'($urandom_range(0, 1)),
            !halted_seen && ($urandom_range(0, 299) == 0));
      if (bus.halt) halted_seen = 1;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    cyc();
    chk_en = 1;
    cyc();
    rst = 1'b0;

    // 1. reset state
    #1;
    check("rst_rd_data",  bus.rd_data, 32'h0);
    check("rst_err",      {31'b0, bus.err}, 32'h0);
    check("rst_rd_count", {16'b0, bus.rd_count}, 32'h0);
    check("rst_wr_count", {16'b0, bus.wr_count}, 32'h0);
    check("rst_rd_valid", {31'b0, bus.rd_valid}, 32'h0);

    // Fill every word so later reads of untouched words have a known value.
    for (int i = 0; i < DEPTH; i++) begin
      drive(i * 4, $urandom, 4'hF, 1'b0, 1'b0);
      cyc();
    end
    do_reset();

    // 2. store / load
    drive(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0); cyc();
    drive(32'h10, 32'h0, 4'h0, 1'b0, 1'b0);        cyc();
    drive(32'h0, 32'h0, 4'h0, 1'b1, 1'b0);         #1;
    check("t2_rd_data",  bus.rd_data, 32'hDEADBEEF);
    check("t2_rd_valid", {31'b0, bus.rd_valid}, 32'h1);
    check("t2_wr_count", {16'b0, bus.wr_count}, 32'h1);
    cyc();
    bus.read_enable = 1'b0;
    check("t2_rd_count", {16'b0, bus.rd_count}, 32'h1);

    // 3. byte enables
    drive(32'h10, 32'h11223344, 4'b0101, 1'b0, 1'b0); cyc();
    drive(32'h10, 32'h0, 4'h0, 1'b0, 1'b0);           cyc();
    bus.read_enable = 1'b1; #1;
    check("t3_rd_data", bus.rd_data, 32'hDE22BE44);
    check("t3_model",   m_rd_data,   32'hDE22BE44);
    cyc();

    // 4. write-first collision
    drive(32'h20, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0); cyc();
    drive(32'h24, 32'h0, 4'h0, 1'b1, 1'b0);        #1;
    check("t4_rd_data",  bus.rd_data, 32'hA5A5A5A5);
    check("t4_rd_valid", {31'b0, bus.rd_valid}, 32'h1);
    cyc();

    // 5. errors
    drive(32'h3, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0); cyc();
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);        #1;
    check("t5_err",      {31'b0, bus.err}, 32'h1);
    check("t5_err_addr", bus.err_addr, 32'h3);
    check("t5_wr_count", {16'b0, bus.wr_count}, 32'h3);
    drive(DEPTH * 4, 32'h12345678, 4'hF, 1'b0, 1'b0); cyc();
    drive(DEPTH * 4, 32'h0, 4'h0, 1'b0, 1'b0);        #1;
    check("t5_err_addr_kept", bus.err_addr, 32'h3);
    cyc();
    drive(32'h0, 32'h0, 4'h0, 1'b1, 1'b0); #1;
    check("t5_ill_rd_data",  bus.rd_data, 32'h0);
    check("t5_ill_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
    cyc();
    bus.read_enable = 1'b0; #1;
    check("t5_word0_intact", bus.rd_data, m_mem[0]);
    check("t5_err_addr_end", bus.err_addr, 32'h3);

    // 6. halt
    do_reset();
    drive(32'h44, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0); cyc();
    drive(32'h44, 32'h0, 4'h0, 1'b1, 1'b0);        #1;
    check("t6_pre_rd_data", bus.rd_data, 32'hCAFEF00D);
    cyc();
    drive(32'h40, 32'h12345678, 4'hF, 1'b0, 1'b1); cyc();
    for (int i = 0; i < 5; i++) begin
      drive(32'h44 - 4 * (i % 2), 32'h0, 4'hF, 1'b1, 1'b0);
      cyc();
    end
    check("t6_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
    check("t6_wr_count", {16'b0, bus.wr_count}, 32'h1);
    check("t6_rd_count", {16'b0, bus.rd_count}, 32'h1);
    do_reset();
    drive(32'h40, 32'h0, 4'h0, 1'b0, 1'b0); #1;
    check("t6_rst_rd_count", {16'b0, bus.rd_count}, 32'h0);
    check("t6_rst_wr_count", {16'b0, bus.wr_count}, 32'h0);
    cyc();
    drive(32'h44, 32'h0, 4'h0, 1'b1, 1'b0); #1;
    check("t6_dropped_write", bus.rd_data, m_mem[16]);
    check("t6_rd_valid_run",  {31'b0, bus.rd_valid}, 32'h1);
    cyc();
    bus.read_enable = 1'b0; #1;
    check("t6_mem_kept", bus.rd_data, 32'hCAFEF00D);

    for (int s = 0; s < 4; s++) random_segment(700);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
